// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous font ROM among N_REQ text-overlay
// requesters, routing each returned glyph line back through a tag pipeline.
module font_rom_arbiter #(
  parameter int N_REQ   = 6,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [N_REQ*DATA_W-1:0]   rsp_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = ROM_LAT + 1;

  logic [IDX_W-1:0]  last_reg;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic              tag_valid_reg [DEPTH];
  logic [IDX_W-1:0]  tag_idx_reg   [DEPTH];
  logic [N_REQ-1:0]  rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg  [N_REQ];

  // Search starts one past the last winner and wraps, so the first hit wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    sel_addr = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_any && req[i] && (i == ((int'(last_reg) + k) % N_REQ))) begin
          gnt_any  = 1'b1;
          gnt_idx  = IDX_W'(i);
          sel_addr = addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
    if (!rst) begin
      gnt_any = 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
      assign gnt[gi]                       = gnt_any && (gnt_idx == IDX_W'(gi));
      assign rsp_data[gi*DATA_W +: DATA_W] = rsp_data_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg     <= IDX_W'(N_REQ - 1);
      rom_addr_reg <= '0;
    end else if (gnt_any) begin
      last_reg     <= gnt_idx;
      rom_addr_reg <= sel_addr;
    end
  end

  // Stage 0 lines up with rom_addr; the last stage lines up with rom_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_idx_reg[s]   <= '0;
      end
    end else begin
      tag_valid_reg[0] <= gnt_any;
      tag_idx_reg[0]   <= gnt_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_idx_reg[s]   <= tag_idx_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_reg <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid_reg[i] <= tag_valid_reg[DEPTH-1] && (tag_idx_reg[DEPTH-1] == IDX_W'(i));
        if (tag_valid_reg[DEPTH-1] && (tag_idx_reg[DEPTH-1] == IDX_W'(i))) begin
          rsp_data_reg[i] <= rom_data;
        end
      end
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign rsp_valid = rsp_valid_reg;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter: a reference arbiter predicts grants at the
// falling edge and queues the expected glyph line, popped when its response is due.
module tb_font_rom_arbiter;

  localparam int N_REQ  = 6;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int LAT    = 3;  // gnt cycle to rsp_valid cycle

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ*DATA_W-1:0] rsp_data;

  typedef struct {
    int              idx;
    logic [DATA_W-1:0] data;
    int              due;
  } exp_t;

  exp_t                    sb [$];
  exp_t                    e;
  int                      n_checks = 0;
  int                      n_fail   = 0;
  int                      cyc      = 0;
  int                      last     = N_REQ - 1;
  int                      g;
  bit                      found;
  logic [ADDR_W-1:0]       exp_rom  = '0;
  logic [N_REQ-1:0]        exp_v;
  logic [N_REQ-1:0]        exp_g;
  logic [N_REQ*DATA_W-1:0] shadow   = '0;

  font_rom_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_line(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m = a * 11'd29;
    return m[7:0] ^ {1'b0, a[10:4]};
  endfunction

  // One-cycle synchronous font ROM.
  always @(posedge clk) rom_data <= rom_line(rom_addr);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check_val("rst_gnt", 64'(gnt), 64'd0);
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_val("rst_rsp_data", 64'(rsp_data), 64'd0);
      check_val("rst_rom_addr", 64'(rom_addr), 64'd0);
      sb.delete();
      shadow  = '0;
      last    = N_REQ - 1;
      exp_rom = '0;
    end else begin
      check_val("rom_addr", 64'(rom_addr), 64'(exp_rom));
      exp_v = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        exp_v[e.idx] = 1'b1;
        shadow[e.idx*DATA_W +: DATA_W] = e.data;
        $display("cyc %0d rsp req%0d data=%h", cyc, e.idx, e.data);
      end
      check_val("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      check_val("rsp_data", 64'(rsp_data), 64'(shadow));
      exp_g = '0;
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        if (!found && req[(last + k) % N_REQ]) begin
          found = 1'b1;
          g     = (last + k) % N_REQ;
        end
      end
      if (found) begin
        exp_g[g] = 1'b1;
        exp_rom  = addr[g*ADDR_W +: ADDR_W];
        sb.push_back('{g, rom_line(exp_rom), cyc + LAT});
        last = g;
        $display("cyc %0d gnt req%0d addr=%h", cyc, g, exp_rom);
      end
      check_val("gnt", 64'(gnt), 64'(exp_g));
    end
  end

  task automatic drive(input logic [N_REQ-1:0] r, input int n);
    req = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    #2 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 req = N_REQ'($urandom);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive('0, 1);

    // First access after reset goes to requester 0
    set_addr(0, 11'h413);
    drive(6'b000001, 1);
    drive('0, 5);

    // Single pulsed requester
    set_addr(3, 11'h210);
    drive(6'b001000, 1);
    drive('0, 5);

    // All requesting: rotation 0..5 twice
    for (int i = 0; i < N_REQ; i++) set_addr(i, ADDR_W'($urandom));
    drive(6'b111111, 12);
    drive('0, 5);

    // Wrap and skip from last grant 4
    drive(6'b010000, 1);
    drive(6'b000101, 3);
    drive('0, 5);

    // Back-to-back reads from one requester
    for (int j = 0; j < 3; j++) begin
      set_addr(1, ADDR_W'(11'h100 + j));
      drive(6'b000010, 1);
    end
    drive('0, 5);

    // Reset while a read is in flight
    set_addr(2, 11'h2ab);
    drive(6'b000100, 1);
    rst = 1'b0;
    drive('0, 1);
    rst = 1'b1;
    drive(6'b111111, 6);
    drive('0, 6);

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares one synchronous font ROM (addr 11 b = char_code[10:4] & char_line[3:0], 8-b line pixels, 1-cycle read latency) among several text-overlay requesters.
- Replaces one font ROM per dialog text line; each game text source requests glyph lines through this block.
- Round-robin arbitration, one ROM access per cycle, pipelined response routing with per-requester hold registers.

Parameters:
- N_REQ, 6, number of requesters
- ADDR_W, 11, ROM address width
- DATA_W, 8, ROM data width (one glyph line)
- ROM_LAT, 1, ROM read latency in cycles; must be >= 1

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester read request; held until granted
- addr  input  N_REQ*ADDR_W  per-requester ROM address; slice i = addr[i*ADDR_W +: ADDR_W]; stable while req[i]=1
- gnt  output  N_REQ  one-hot grant, combinational, same cycle as request acceptance
- rom_addr  output  ADDR_W  registered address to font ROM
- rom_data  input  DATA_W  font ROM read data, ROM_LAT cycles after rom_addr
- rsp_valid  output  N_REQ  one-cycle pulse per completed read
- rsp_data  output  N_REQ*DATA_W  per-requester last returned glyph line, held

Behaviour:
- Reset (rst=0, async): gnt=0, rom_addr=0, rsp_valid=0, rsp_data=0, pointer so requester 0 has highest priority, tag pipeline cleared.
- Arbitration: priority order starts at (last_granted+1) mod N_REQ, wraps around; gnt = first asserted req in that order; gnt=0 when req=0. At most one gnt bit per cycle.
- Accept: on clk edge ending cycle t with gnt[i]=1: rom_addr <= addr slice i; last_granted <= i; tag {valid=1, idx=i} enters pipeline.
- No grant: rom_addr holds; tag entering pipeline has valid=0; pointer unchanged.
- Tag pipeline depth ROM_LAT+1: address register stage plus ROM latency.
- Timing (ROM_LAT=1): gnt in cycle t; rom_addr valid cycle t+1; rom_data valid cycle t+2; captured at end of t+2; rsp_valid[i]=1 and rsp_data slice i updated in cycle t+3. Request to response = ROM_LAT+2 cycles after gnt cycle.
- Throughput: one access per cycle sustained; back-to-back grants to different or the same requester are independent pipeline entries.
- rsp_data slice i changes only on its own response; other slices hold.
- Requester deasserting req before gnt: legal, nothing issued. req held after gnt issues a new access (requester drops req in cycle after gnt for single read).
- Fairness: with all N_REQ requesting continuously, each granted exactly once per N_REQ cycles.
- rst asserted mid-operation: in-flight tags discarded, no rsp_valid after release; first grant after release follows reset priority.

Test Plan:
- Reset: rst=0 with random req -> gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0; after release req=6'b000001, addr0=0x41_3 -> gnt[0] cycle 0, rom_addr=0x413 cycle 1, rsp_valid[0] cycle 3 with rsp_data0 = ROM model line.
- Single requester: req[3] pulsed, addr3=0x210 -> exactly one rsp_valid[3] pulse 3 cycles after gnt[3]; rsp_data3 = model[0x210], other slices unchanged.
- Round-robin: req=6'b111111 held 12 cycles -> grant order 0,1,2,3,4,5,0,1,... each rsp_valid once per 6 cycles, correct data per slice.
- Wrap/skip: last grant 4, req=6'b000101 -> gnt[0], then gnt[2], then gnt[0].
- Back-to-back: req[1] held 3 cycles, addr1 = 0x100, 0x101, 0x102 -> rsp_valid[1] in 3 consecutive cycles, data in address order.
- Mid-flight reset: gnt[2] then rst=0 for 1 cycle in next cycle -> no rsp_valid[2], rsp_data2=0, next req=6'b111111 grants 0 first.
